// File: rtl/opsum_accumulator_if.sv
// Stream bundle between the PE array, the opsum accumulator and the opsum buffer:
// per-row partial sums with their capture strobe in, drained rows out over valid/ready.
interface opsum_accumulator_if #(
    parameter int ROW_NUM = 32,
    parameter int PSUM_W  = 16,
    parameter int ACC_W   = 32
) ();
    logic [ROW_NUM*PSUM_W-1:0] array_opsum;
    logic                      opsum_valid;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          out_data;
    logic [4:0]                out_row;
    logic                      out_last;

    // Array/buffer side: supplies sums and accepts drained beats.
    modport master (
        output array_opsum,
        output opsum_valid,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last
    );

    // Accumulator side.
    modport slave (
        input  array_opsum,
        input  opsum_valid,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_row,
        output out_last
    );
endinterface

// File: rtl/opsum_accumulator.sv
// Captures per-row partial sums from the PE array once per pass, accumulates them
// over a programmed number of passes, then drains one row per beat downstream.
module opsum_accumulator #(
    parameter int ROW_NUM = 32,
    parameter int PSUM_W  = 16,
    parameter int ACC_W   = 32,
    parameter int PASS_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PASS_W-1:0] num_pass,
    input  logic [5:0]        row_cnt,
    input  logic              relu_en,
    opsum_accumulator_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              drop_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ACC_W-1:0]  acc     [ROW_NUM];
    logic [ACC_W-1:0]  acc_sum [ROW_NUM];

    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] num_pass_q;
    logic [5:0]        row_cnt_q;
    logic              relu_q;

    logic              out_valid_q;
    logic [ACC_W-1:0]  out_data_q;
    logic [4:0]        out_row_q;
    logic              out_last_q;

    logic              out_valid_nxt;
    logic [ACC_W-1:0]  out_data_nxt;
    logic [4:0]        out_row_nxt;
    logic              out_last_nxt;

    logic              capture;
    logic              final_cap;
    logic [PASS_W:0]   pass_inc;
    logic [5:0]        row_inc;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_last_q;

    assign capture   = (state == ACCUM) && bus.opsum_valid;
    assign pass_inc  = {1'b0, pass_cnt} + (PASS_W+1)'(1);
    assign final_cap = capture && (pass_inc == {1'b0, num_pass_q});
    assign row_inc   = {1'b0, out_row_q} + 6'd1;

    function automatic logic [ACC_W-1:0] relu_f(input logic en, input logic [ACC_W-1:0] v);
        return (en && v[ACC_W-1]) ? '0 : v;
    endfunction

    // Sign-extend every lane and add it to its accumulator (wraps modulo 2^ACC_W).
    always_comb begin
        for (int unsigned r = 0; r < ROW_NUM; r++) begin
            acc_sum[r] = acc[r] + ACC_W'($signed(bus.array_opsum[r*PSUM_W +: PSUM_W]));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and next output-beat selection.
    // The first beat is loaded from the sum being written on the final capture edge,
    // so it is valid the very next cycle instead of waiting a cycle for acc to settle.
    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid_q;
        out_data_nxt  = out_data_q;
        out_row_nxt   = out_row_q;
        out_last_nxt  = out_last_q;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = ACCUM;
            end
            ACCUM: begin
                if (final_cap) begin
                    if (row_cnt_q == 6'd0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt     = DRAIN;
                        out_valid_nxt = 1'b1;
                        out_row_nxt   = '0;
                        out_data_nxt  = relu_f(relu_q, acc_sum[0]);
                        out_last_nxt  = (row_cnt_q == 6'd1);
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_nxt     = DONE;
                        out_valid_nxt = 1'b0;
                        out_last_nxt  = 1'b0;
                    end else begin
                        out_row_nxt  = row_inc[4:0];
                        out_data_nxt = relu_f(relu_q, acc[row_inc[4:0]]);
                        out_last_nxt = ((row_inc + 6'd1) == row_cnt_q);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Registered outputs, status flags and the drop-error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            drop_err    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_nxt;
            out_data_q  <= out_data_nxt;
            out_row_q   <= out_row_nxt;
            out_last_q  <= out_last_nxt;
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == DONE);
            drop_err    <= bus.opsum_valid && (state != ACCUM);
        end
    end

    // Job configuration latch and pass counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            num_pass_q <= '0;
            row_cnt_q  <= '0;
            relu_q     <= 1'b0;
            pass_cnt   <= '0;
        end else if (state == IDLE && start) begin
            num_pass_q <= (num_pass == '0) ? PASS_W'(1) : num_pass;
            row_cnt_q  <= (row_cnt > 6'(ROW_NUM)) ? 6'(ROW_NUM) : row_cnt;
            relu_q     <= relu_en;
            pass_cnt   <= '0;
        end else if (capture) begin
            pass_cnt   <= pass_inc[PASS_W-1:0];
        end
    end

    // Per-row accumulators: cleared at job start, updated on each capture.
    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && start)) begin
            for (int unsigned r = 0; r < ROW_NUM; r++) acc[r] <= '0;
        end else if (capture) begin
            for (int unsigned r = 0; r < ROW_NUM; r++) acc[r] <= acc_sum[r];
        end
    end

endmodule

// File: tb/tb_opsum_accumulator.sv
// Self-checking bench for opsum_accumulator: table of jobs plus hand-written
// backpressure, drop, start-ignore and mid-drain reset sequences.
module tb_opsum_accumulator;
    localparam int ROW_NUM = 32;
    localparam int PSUM_W  = 16;
    localparam int ACC_W   = 32;
    localparam int PASS_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [PASS_W-1:0] num_pass;
    logic [5:0]        row_cnt;
    logic              relu_en;
    logic              busy;
    logic              done;
    logic              drop_err;

    opsum_accumulator_if #(.ROW_NUM(ROW_NUM), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) bus ();

    opsum_accumulator #(
        .ROW_NUM(ROW_NUM),
        .PSUM_W (PSUM_W),
        .ACC_W  (ACC_W),
        .PASS_W (PASS_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .num_pass(num_pass),
        .row_cnt (row_cnt),
        .relu_en (relu_en),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // pat 0: every pass, lane r = r+1 -> expected row r = scale*(r+1)
    // pat 1: row0 = 7FFF,7FFF,8000 ; row1 = FFFF each pass ; others 0 -> r0/r1 given
    typedef struct {
        logic [4:0]  np;
        logic [5:0]  rc;
        logic        relu;
        int          pat;
        int          caps;
        int          beats;
        int          scale;
        logic [31:0] r0;
        logic [31:0] r1;
    } vec_t;

    vec_t vecs [7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input vec_t v, input int r);
        if (v.pat == 0) return 32'(v.scale * (r + 1));
        if (r == 0) return v.r0;
        if (r == 1) return v.r1;
        return 32'h0;
    endfunction

    task automatic drive_pass(input int pat, input int p);
        logic [ROW_NUM*PSUM_W-1:0] v;
        v = '0;
        for (int r = 0; r < ROW_NUM; r++) begin
            logic [15:0] lane;
            if (pat == 0)    lane = 16'(r + 1);
            else if (r == 0) lane = (p < 2) ? 16'h7FFF : 16'h8000;
            else if (r == 1) lane = 16'hFFFF;
            else             lane = 16'h0000;
            v[r*PSUM_W +: PSUM_W] = lane;
        end
        bus.array_opsum = v;
        bus.opsum_valid = 1'b1;
        tick();
        bus.opsum_valid = 1'b0;
        bus.array_opsum = {ROW_NUM{16'h1234}};
    endtask

    task automatic start_job(input logic [4:0] np, input logic [5:0] rc, input logic relu);
        num_pass = np;
        row_cnt  = rc;
        relu_en  = relu;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   got;
        int   cyc;
        bit   seen_done;
        v = vecs[i];
        bus.out_ready = 1'b1;
        start_job(v.np, v.rc, v.relu);
        chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
        for (int p = 0; p < v.caps; p++) begin
            if (p == 1) tick();
            drive_pass(v.pat, p);
        end
        chk($sformatf("v%0d first_valid", i), 32'(bus.out_valid), 32'(v.beats > 0));
        got = 0;
        cyc = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 200) begin
            if (bus.out_valid) begin
                chk($sformatf("v%0d row", i), 32'(bus.out_row), 32'(got));
                chk($sformatf("v%0d data r%0d", i, got), bus.out_data, exp_data(v, got));
                chk($sformatf("v%0d last r%0d", i, got), 32'(bus.out_last), 32'(got == v.beats - 1));
                got++;
            end
            if (done) seen_done = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        chk($sformatf("v%0d done_seen", i), 32'(seen_done), 32'd1);
        chk($sformatf("v%0d beats", i), 32'(got), 32'(v.beats));
        chk($sformatf("v%0d done_cycle", i), 32'(cyc), 32'(v.beats));
        chk($sformatf("v%0d valid_at_done", i), 32'(bus.out_valid), 32'd0);
        tick();
        chk($sformatf("v%0d done_pulse", i), 32'(done), 32'd0);
        chk($sformatf("v%0d idle", i), 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc;

        vecs[0] = '{5'd1, 6'd32, 1'b0, 0, 1, 32, 1, 32'h0, 32'h0};
        vecs[1] = '{5'd3, 6'd32, 1'b0, 1, 3, 32, 0, 32'h00007FFE, 32'hFFFFFFFD};
        vecs[2] = '{5'd3, 6'd32, 1'b1, 1, 3, 32, 0, 32'h00007FFE, 32'h00000000};
        vecs[3] = '{5'd0, 6'd8,  1'b0, 0, 1, 8,  1, 32'h0, 32'h0};
        vecs[4] = '{5'd2, 6'd40, 1'b0, 0, 2, 32, 2, 32'h0, 32'h0};
        vecs[5] = '{5'd0, 6'd0,  1'b0, 0, 1, 0,  1, 32'h0, 32'h0};
        vecs[6] = '{5'd4, 6'd3,  1'b1, 0, 4, 3,  4, 32'h0, 32'h0};

        reset = 1'b1;
        start = 1'b0;
        num_pass = '0;
        row_cnt = '0;
        relu_en = 1'b0;
        bus.array_opsum = '0;
        bus.opsum_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst out_data", bus.out_data, 32'd0);
        chk("rst out_row", 32'(bus.out_row), 32'd0);
        chk("rst out_last", 32'(bus.out_last), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst drop_err", 32'(drop_err), 32'd0);
        reset = 1'b0;
        tick();

        // Capture strobe while idle: dropped and flagged.
        bus.array_opsum = {ROW_NUM{16'h7FFF}};
        bus.opsum_valid = 1'b1;
        tick();
        bus.opsum_valid = 1'b0;
        chk("idle drop_err", 32'(drop_err), 32'd1);
        chk("idle drop busy", 32'(busy), 32'd0);
        tick();
        chk("idle drop_err clear", 32'(drop_err), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Backpressure: 4 rows, ready low 3 cycles per beat.
        bus.out_ready = 1'b0;
        start_job(5'd1, 6'd4, 1'b0);
        drive_pass(0, 0);
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < 3; s++) begin
                chk($sformatf("bp valid b%0d", b), 32'(bus.out_valid), 32'd1);
                chk($sformatf("bp row b%0d", b), 32'(bus.out_row), 32'(b));
                chk($sformatf("bp data b%0d", b), bus.out_data, 32'(b + 1));
                chk($sformatf("bp last b%0d", b), 32'(bus.out_last), 32'(b == 3));
                if (b == 1 && s == 0) begin
                    bus.array_opsum = {ROW_NUM{16'h0100}};
                    bus.opsum_valid = 1'b1;
                    tick();
                    bus.opsum_valid = 1'b0;
                    chk("drain drop_err", 32'(drop_err), 32'd1);
                end else begin
                    tick();
                end
            end
            chk($sformatf("bp hold row b%0d", b), 32'(bus.out_row), 32'(b));
            chk($sformatf("bp hold data b%0d", b), bus.out_data, 32'(b + 1));
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
        end
        chk("bp done", 32'(done), 32'd1);
        chk("bp valid after", 32'(bus.out_valid), 32'd0);
        tick();
        chk("bp idle", 32'(busy), 32'd0);

        // start during DRAIN must be ignored.
        bus.out_ready = 1'b1;
        start_job(5'd1, 6'd4, 1'b0);
        drive_pass(0, 0);
        chk("sd row0", 32'(bus.out_row), 32'd0);
        num_pass = 5'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sd row1", 32'(bus.out_row), 32'd1);
        chk("sd valid1", 32'(bus.out_valid), 32'd1);
        tick();
        chk("sd row2", 32'(bus.out_row), 32'd2);
        tick();
        chk("sd row3", 32'(bus.out_row), 32'd3);
        chk("sd last3", 32'(bus.out_last), 32'd1);
        tick();
        chk("sd done", 32'(done), 32'd1);
        tick();
        chk("sd idle", 32'(busy), 32'd0);
        tick();
        chk("sd still idle", 32'(busy), 32'd0);

        // Reset mid-DRAIN at row 5.
        start_job(5'd1, 6'd32, 1'b0);
        drive_pass(0, 0);
        cyc = 0;
        while (bus.out_row != 5'd5 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("mr at row5", 32'(bus.out_row), 32'd5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr busy", 32'(busy), 32'd0);
        chk("mr done", 32'(done), 32'd0);
        tick();
        chk("mr done later", 32'(done), 32'd0);
        chk("mr valid later", 32'(bus.out_valid), 32'd0);
        run_vec(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/opsum_accumulator.md
Name: opsum_accumulator

Overview:
- Sits downstream of the 32×32 PE array. Captures the per-row 16-bit reduced partial sums (`array_opsum`) once per compute pass.
- Accumulates them across a programmed number of passes into wide per-row accumulators.
- Drains the finished rows one per beat over a valid/ready stream toward the opsum buffer.
- Receiver/consumer end of the PE array output interface.

Parameters:
- ROW_NUM, 32, rows in the PE array, i.e. number of 16-bit lanes in `array_opsum`.
- PSUM_W, 16, width of each row partial sum.
- ACC_W, 32, accumulator and output data width; must be ≥ PSUM_W.
- PASS_W, 5, width of the pass-count field.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- num_pass  in  PASS_W  passes to accumulate; 0 treated as 1.
- row_cnt  in  6  active rows to drain, 0..ROW_NUM; values > ROW_NUM clamp to ROW_NUM.
- relu_en  in  1  apply ReLU on drain.
- array_opsum  in  ROW_NUM*PSUM_W  row r at bits [r*PSUM_W +: PSUM_W].
- opsum_valid  in  1  one-cycle capture strobe, asserted once per pass.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  ACC_W  accumulated row value.
- out_row  out  5  row index of current beat.
- out_last  out  1  final beat of job.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse at job end.
- drop_err  out  1  one-cycle pulse when `opsum_valid` arrives outside ACCUM.

Behaviour:
- Reset (sync, `reset`=1 at an edge):
  - State goes to IDLE; all accumulators, counters and the latched config clear to 0.
  - `out_valid`, `out_last`, `busy`, `done`, `drop_err` = 0; `out_data` = 0; `out_row` = 0.
  - Reset mid-job aborts immediately: no `done` and no further beats.
- States are IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `num_pass` (0→1), `row_cnt` (clamped) and `relu_en`.
  - Clears all ROW_NUM accumulators and the pass counter, then goes to ACCUM.
  - `start` in any other state is ignored.
- ACCUM:
  - Each `opsum_valid` cycle sign-extends every row lane (PSUM_W signed two's complement) to ACC_W and adds it to its accumulator at the edge.
  - Addition wraps modulo 2^ACC_W; there is no saturation.
  - The pass counter increments on each capture.
  - On the capture that makes count == `num_pass`, the next state is DRAIN, or DONE if `row_cnt`==0.
- DRAIN:
  - First beat appears the cycle after the final capture edge, with `out_valid`=1, `out_row`=0.
  - `out_data` = acc[out_row], forced to 0 if `relu_en` and the value is negative.
  - `out_data`, `out_row` and `out_last` hold stable while `out_valid` && !`out_ready`.
  - A transfer occurs when `out_valid` && `out_ready`; the next beat (`out_row`+1) is presented the following cycle with no bubble.
  - `out_last`=1 when `out_row` == `row_cnt`−1.
  - The transfer of the last beat goes to DONE; `out_valid` drops the next cycle.
- DONE: `done`=1 for exactly one cycle, then IDLE. `busy` falls together with the return to IDLE.
- `opsum_valid` in IDLE, DRAIN or DONE:
  - Data is discarded; accumulators are not touched.
  - `drop_err` pulses the next cycle.
- Latency:
  - Final capture to first `out_valid`: 1 cycle.
  - Minimum job with P passes and R rows and `out_ready` tied high: P capture cycles + R beats + 1 DONE cycle.
- Output signals are registered: no combinational path from `array_opsum` or `out_ready` to any output.

Test Plan:
- Basic job:
  - Stimulus: `num_pass`=1, `row_cnt`=32, `array_opsum` row r = r+1, `out_ready`=1.
  - Required: 32 consecutive beats, `out_data`=1..32, `out_row`=0..31, `out_last` only on row 31, then a `done` pulse.
- Multi-pass signed:
  - Stimulus: `num_pass`=3; row 0 lanes 0x7FFF, 0x7FFF, 0x8000; row 1 = 0xFFFF each pass.
  - Required: row 0 = 32766 (0x00007FFE), row 1 = −3 (0xFFFFFFFD).
- ReLU:
  - Stimulus: same as multi-pass with `relu_en`=1.
  - Required: row 0 = 32766, row 1 = 0.
- Backpressure:
  - Stimulus: `row_cnt`=4, `out_ready` low for 3 cycles on each beat.
  - Required: each beat's `out_data`/`out_row` stable while stalled, exactly 4 transfers, no duplicated or skipped rows.
- Boundaries:
  - `num_pass`=0 behaves as 1.
  - `row_cnt`=40 drains 32 rows.
  - `row_cnt`=0 gives `done` 1 cycle after capture with no beats.
  - `start` during DRAIN is ignored.
- Errors / reset:
  - `opsum_valid` in IDLE → `drop_err` pulse, next job's sums unaffected.
  - `reset` asserted mid-DRAIN at row 5 → next cycle `out_valid`=0, `busy`=0, no `done`; a new job then returns correct fresh sums.
